// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the mem_responder SRAM model.
// The LFSR constants are only used when MEM_RESPONDER_RANDOM_STALL_EN is defined.
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

package mem_responder_pkg;
    localparam int ADDR_W   = `RISCV_ADDR_WIDTH;
    localparam int WORD_W   = `RISCV_WORD_WIDTH;
    localparam int BE_WIDTH = 4;
    localparam int LFSR_W   = 16;
    // Taps 16,14,13,11 map to state bits 15,13,12,10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] data;
    } resp_t;

    function automatic logic [WORD_W-1:0] apply_be(input logic [WORD_W-1:0] old_w,
                                                   input logic [WORD_W-1:0] new_w,
                                                   input logic [BE_WIDTH-1:0] be);
        logic [WORD_W-1:0] r;
        r = old_w;
        for (int k = 0; k < BE_WIDTH; k++)
            if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
        return r;
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/mem_responder_if.sv
// req/gnt/rvalid memory bus between an initiator (master) and mem_responder (slave).
interface mem_responder_if;
    logic                                     req_i;
    logic                                     gnt_o;
    logic [mem_responder_pkg::ADDR_W-1:0]     addr_i;
    logic                                     we_i;
    logic [mem_responder_pkg::BE_WIDTH-1:0]   be_i;
    logic [mem_responder_pkg::WORD_W-1:0]     wdata_i;
    logic                                     rvalid_o;
    logic [mem_responder_pkg::WORD_W-1:0]     rdata_o;

    modport master (output req_i, addr_i, we_i, be_i, wdata_i,
                    input  gnt_o, rvalid_o, rdata_o);
    modport slave  (input  req_i, addr_i, we_i, be_i, wdata_i,
                    output gnt_o, rvalid_o, rdata_o);
endinterface

// File: rtl/mem_resp_pipe.sv
// Fixed-latency response shift pipeline; reset flushes every in-flight response.
module mem_resp_pipe
    import mem_responder_pkg::*;
#(
    parameter int STAGES = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  resp_t d,
    output resp_t q
);
    resp_t [STAGES-1:0] resp_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_pipe <= '0;
        end else begin
            resp_pipe[0] <= d;
            for (int s = 1; s < STAGES; s++)
                resp_pipe[s] <= resp_pipe[s-1];
        end
    end

    assign q = resp_pipe[STAGES-1];
endmodule

// File: rtl/mem_responder.sv
// Word-addressed SRAM answering the req/gnt/rvalid protocol with fixed read latency.
// Optional MEM_RESPONDER_RANDOM_STALL_EN masks grants with an LFSR.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS     = 1024,
    parameter int          READ_LATENCY    = 1,
    parameter int          MAX_OUTSTANDING = 1,
    parameter logic [15:0] STALL_SEED      = 16'hACE1
) (
    input logic           clk,
    input logic           rst,
    mem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic              stall, gnt, accept;
    resp_t             resp_d, resp_q;

`ifdef MEM_RESPONDER_RANDOM_STALL_EN
    logic [LFSR_W-1:0] lfsr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= STALL_SEED;
        else     lfsr <= lfsr_next(lfsr);
    end
    assign stall = lfsr[0];
`else
    localparam logic [15:0] unused_seed = STALL_SEED;
    assign stall = 1'b0;
`endif

    // A slot retiring this cycle (rvalid high) can be handed straight to a new request
    assign gnt    = bus.req_i && ((cnt < MAX_CNT) || resp_q.valid) && !stall && !rst;
    assign accept = gnt;
    assign idx    = bus.addr_i[2 +: IDX_W];

    logic unused_addr;
    assign unused_addr = ^{bus.addr_i[1:0], bus.addr_i[ADDR_W-1:IDX_W+2]};

    always_ff @(posedge clk) begin
        if (accept && bus.we_i)
            mem[idx] <= apply_be(mem[idx], bus.wdata_i, bus.be_i);
    end

    assign resp_d.valid = accept;
    assign resp_d.data  = (accept && !bus.we_i) ? mem[idx] : '0;

    mem_resp_pipe #(.STAGES(READ_LATENCY)) u_pipe (
        .clk (clk),
        .rst (rst),
        .d   (resp_d),
        .q   (resp_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (accept && !resp_q.valid)
            cnt <= cnt + 1'b1;
        else if (!accept && resp_q.valid)
            cnt <= cnt - 1'b1;
    end

    cnt_bound_a: assert property (@(posedge clk) disable iff (rst) cnt <= MAX_CNT);

    assign bus.gnt_o    = gnt;
    assign bus.rvalid_o = resp_q.valid;
    assign bus.rdata_o  = resp_q.data;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: four responders (latency 1..4) driven with directed vectors.
module tb_mem_responder;
    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_all, rst_d;
    logic        req [4];
    logic        we [4];
    logic [31:0] addr [4];
    logic [3:0]  be [4];
    logic [31:0] wdata [4];
    logic        gnt [4];
    logic        rvalid [4];
    logic [31:0] rdata [4];

    exp_t        exp_q [4][$];
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] model [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder_if bus [4] ();

    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic rst_g;
        assign rst_g          = rst_all | ((g == 3) ? rst_d : 1'b0);
        assign bus[g].req_i   = req[g];
        assign bus[g].we_i    = we[g];
        assign bus[g].addr_i  = addr[g];
        assign bus[g].be_i    = be[g];
        assign bus[g].wdata_i = wdata[g];
        assign gnt[g]         = bus[g].gnt_o;
        assign rvalid[g]      = bus[g].rvalid_o;
        assign rdata[g]       = bus[g].rdata_o;

        mem_responder #(
            .DEPTH_WORDS     (1024),
            .READ_LATENCY    (g + 1),
            .MAX_OUTSTANDING ((g == 1) ? 2 : 1),
            .STALL_SEED      (16'hACE1)
        ) u_dut (
            .clk (clk),
            .rst (rst_g),
            .bus (bus[g])
        );
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp_v);
        compared++;
        if (act !== exp_v) begin
            mismatched++;
            $display("FAIL %s dut%0d: got %h expected %h", name, k, act, exp_v);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (rvalid[k] === 1'b1) begin
                    if (exp_q[k].size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_rvalid dut%0d: got rdata %h expected no response", k, rdata[k]);
                    end else begin
                        e = exp_q[k].pop_front();
                        chk("rdata", k, rdata[k], e.data);
                        chk("latency_cycle", k, 32'(cyc), 32'(e.due));
                    end
                end
            end
        end
    endtask

    // Holds req until granted; the expected response is queued when the grant is seen
    task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic [31:0] exp_d, output int waits);
        req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
        waits = 0;
        @(negedge clk);
        while (gnt[k] !== 1'b1 && waits < 64) begin
            @(negedge clk);
            waits++;
        end
        if (gnt[k] !== 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL grant_timeout dut%0d: got no grant expected grant within 64 cycles", k);
        end else begin
            exp_q[k].push_back('{exp_d, cyc + k + 1});
        end
        @(posedge clk); #1;
        req[k] = 1'b0; we[k] = 1'b0; addr[k] = ~a; wdata[k] = ~d; be[k] = ~b;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
        return {b[3] ? n[31:24] : o[31:24], b[2] ? n[23:16] : o[23:16],
                b[1] ? n[15:8]  : o[15:8],  b[0] ? n[7:0]   : o[7:0]};
    endfunction

    initial begin
        int w;
        int timeout;
        logic rw;
        logic [3:0] rb, ri;
        logic [31:0] rd, ra;

        rst_all = 1'b1; rst_d = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req[k] = 1'b1; we[k] = 1'b0; addr[k] = '0; be[k] = '0; wdata[k] = '0;
        end
        fork monitor(); join_none

        @(negedge clk); @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("reset_gnt", k, 32'(gnt[k]), 32'd0);
            chk("reset_rvalid", k, 32'(rvalid[k]), 32'd0);
            chk("reset_rdata", k, rdata[k], 32'd0);
        end
        @(posedge clk); #1;
        rst_all = 1'b0;
        for (int k = 0; k < 4; k++) req[k] = 1'b0;
        @(posedge clk); #1;

        // Latency 1: store/load, byte enables, no-op write, aliasing
        xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, w);
        xfer(0, 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, w);
`ifndef MEM_RESPONDER_RANDOM_STALL_EN
        chk("rl1_next_cycle_grant_waits", 0, 32'(w), 32'd0);
`endif
        xfer(0, 1'b1, 32'h10, 4'b0101, 32'h11223344, 32'h0, w);
        xfer(0, 1'b0, 32'h10, 4'h0, 32'h0, 32'hDE22BE44, w);
        xfer(0, 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, 32'h0, w);
        xfer(0, 1'b0, 32'h10, 4'h0, 32'h0, 32'hDE22BE44, w);
        xfer(0, 1'b1, 32'h0000_1000, 4'hF, 32'hA5A5A5A5, 32'h0, w);
        xfer(0, 1'b0, 32'h0000_0000, 4'h0, 32'h0, 32'hA5A5A5A5, w);
        xfer(0, 1'b0, 32'h0000_0003, 4'h0, 32'h0, 32'hA5A5A5A5, w);

        // Latency 2, two outstanding: back-to-back reads
        xfer(1, 1'b1, 32'h0, 4'hF, 32'h11111111, 32'h0, w);
        xfer(1, 1'b1, 32'h4, 4'hF, 32'h22222222, 32'h0, w);
        xfer(1, 1'b1, 32'h8, 4'hF, 32'h33333333, 32'h0, w);
        xfer(1, 1'b1, 32'hC, 4'hF, 32'h44444444, 32'h0, w);
        for (int i = 0; i < 4; i++) begin
            xfer(1, 1'b0, 32'(4 * i), 4'h0, 32'h0, {4{8'(8'h11 * (i + 1))}}, w);
`ifndef MEM_RESPONDER_RANDOM_STALL_EN
            chk("b2b_grant_waits", 1, 32'(w), 32'd0);
`endif
        end

        // Latency 3, one outstanding: grants only every third cycle
        xfer(2, 1'b1, 32'h8, 4'hF, 32'hCAFEF00D, 32'h0, w);
        for (int i = 0; i < 3; i++) begin
            xfer(2, 1'b0, 32'h8, 4'h0, 32'h0, 32'hCAFEF00D, w);
`ifndef MEM_RESPONDER_RANDOM_STALL_EN
            chk("limit_grant_waits", 2, 32'(w), 32'd2);
`endif
        end

        // Latency 4: reset while a read is in flight
        xfer(3, 1'b1, 32'h20, 4'hF, 32'h13579BDF, 32'h0, w);
        xfer(3, 1'b0, 32'h20, 4'h0, 32'h0, 32'h13579BDF, w);
        @(posedge clk); #1;
        rst_d = 1'b1;
        exp_q[3].delete();
        req[3] = 1'b1; we[3] = 1'b0; addr[3] = 32'h20;
        @(negedge clk);
        chk("gnt_during_reset", 3, 32'(gnt[3]), 32'd0);
        @(posedge clk); #1;
        rst_d = 1'b0; req[3] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        xfer(3, 1'b0, 32'h20, 4'h0, 32'h0, 32'h13579BDF, w);
`ifndef MEM_RESPONDER_RANDOM_STALL_EN
        chk("post_reset_grant_waits", 3, 32'(w), 32'd0);
`endif

        // Mixed traffic on latency 1 over 16 aliased words
        for (int i = 0; i < 16; i++) begin
            model[i] = 32'h1000_0000 + 32'(i);
            xfer(0, 1'b1, 32'(4 * i), 4'hF, model[i], 32'h0, w);
        end
        for (int i = 0; i < 1000; i++) begin
            rw = 1'(($urandom() >> 5) & 1);
            ri = 4'($urandom_range(0, 15));
            rb = 4'($urandom());
            rd = $urandom();
            ra = {19'($urandom()), 1'b0, 4'b0, 2'b0, ri, 2'($urandom())};
            if (rw) begin
                xfer(0, 1'b1, ra, rb, rd, 32'h0, w);
                model[ri] = merge(model[ri], rd, rb);
            end else begin
                xfer(0, 1'b0, ra, rb, rd, model[ri], w);
            end
        end

        timeout = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0 && timeout < 200) begin
            @(posedge clk);
            timeout++;
        end
        for (int k = 0; k < 4; k++) chk("drained_queue", k, 32'(exp_q[k].size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
